problema1_pio_ext: RTL and testbench
====================================

Name: problema1_pio_ext

Overview:
Parametrised Avalon-MM general-purpose I/O slave; successor to the team's fixed 2-bit output-only PIO. Per-bit direction control, input synchronisation, edge capture, maskable interrupt, atomic set/clear of output bits. Sits on the Nios II data master beside the other memory-mapped peripherals.

Parameters:
WIDTH, 8, number of I/O bits (1..32)
RESET_VALUE, 0, out register value after reset (WIDTH bits)
EDGE_TYPE, 0, capture edge: 0 rising, 1 falling, 2 any
IRQ_TYPE, 1, 0 level-sensitive, 1 edge-capture-driven
SYNC_STAGES, 2, input synchroniser depth (>=2)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
address  input  3  word register index
chipselect  input  1  slave select
write_n  input  1  active-low write strobe; read = chipselect & write_n
writedata  input  32  write data; bits above WIDTH ignored
readdata  output  32  registered read data, zero-extended
in_port  input  WIDTH  external pin inputs (asynchronous)
out_port  output  WIDTH  output data register
oe_port  output  WIDTH  per-bit output enable (= direction register)
irq  output  1  interrupt request, active-high

Behaviour:
- One clock; reset is asynchronous and active-high. All state clears immediately on reset assertion, independent of clk.
- Reset values: out_port=RESET_VALUE, oe_port=0 (all inputs), irqmask=0, edge_capture=0, synchroniser=0, readdata=0, irq=0.
- Write = chipselect & ~write_n, taken on rising clk. Register map (address):
  0 DATA: write loads out; read returns (sync_in & ~dir) | (out & dir).
  1 DIRECTION: 1 = output. R/W.
  2 IRQMASK: R/W.
  3 EDGECAPTURE: read returns capture bits; write-1-to-clear, write-0 no effect.
  4 OUTSET: write ORs data into out; reads 0.
  5 OUTCLEAR: write clears out bits set in data; reads 0.
  6,7: reads 0, writes ignored.
- Read latency 1: readdata updated on the clk edge where chipselect & write_n; otherwise holds. Value reflects register state before any same-cycle write.
- in_port passes SYNC_STAGES flops (sync_in); one further flop (prev) for edge detection. Pin-to-capture latency SYNC_STAGES+1 cycles.
- Edge detect per bit: rising = sync_in & ~prev; falling = ~sync_in & prev; any = XOR. Detected only on bits with dir=0; output bits never capture.
- Same-cycle edge and write-1-to-clear on one bit: edge wins, bit stays set.
- irq is registered: IRQ_TYPE=1 -> next irq = |(edge_capture & irqmask); IRQ_TYPE=0 -> |(sync_in & ~dir & irqmask). Irq lags source by one cycle.
- Changing a bit dir 1->0 must not produce a spurious edge: prev follows sync_in continuously irrespective of dir.
- writedata bits [31:WIDTH] ignored; readdata [31:WIDTH] always 0.

Decomposition:
- Package problema1_pio_pkg: register address constants (ADDR_DATA..ADDR_OUTCLEAR), EDGE_* and IRQ_* encoding constants.
- One sub-module: problema1_pio_sync (parametrised WIDTH/SYNC_STAGES synchroniser plus prev flop, emits sync_in and edge vector for given EDGE_TYPE).
- Register file, read mux, irq in the top module.

Test Plan:
- Reset mid-run: out=0xA5, dir=0xFF, assert reset asynchronously between clk edges -> out_port=RESET_VALUE, oe_port=0x00, irq=0 immediately, no clk required.
- Set/clear: write DATA=0x0F, OUTSET=0x30, OUTCLEAR=0x05 -> out_port 0x0F, 0x3F, 0x3A on successive cycles; read addr 0 with dir=0xFF returns 0x3A one cycle after read.
- Mixed read: dir=0xF0, out=0xA0, in_port=0x05 held -> read DATA returns 0xA5; read addr 4 returns 0.
- Rising edge irq (EDGE_TYPE=0, IRQ_TYPE=1): irqmask=0x01, in_port bit0 0->1 -> edge_capture=0x01 after SYNC_STAGES+1 cycles, irq=1 one cycle later; write 0x01 to addr 3 -> capture 0, irq drops next cycle.
- Clear/edge collision: new rising edge on bit2 in same cycle as write 0x04 to EDGECAPTURE -> bit2 remains 1; masked bit (irqmask=0) captures but irq stays 0.
- Output-bit exclusion / direction change: dir bit3=1, toggle in_port[3] -> no capture; switch dir bit3 to 0 with in_port[3] static high -> no capture, irq stays 0.

Source files
------------

// File: rtl/problema1_pio_pkg.sv
// ---------------------------------------------------------------------------
// problema1_pio_pkg
// Shared constants for the parametrised PIO slave:
//   - word addresses of the memory-mapped registers
//   - encodings of the edge-capture mode (EDGE_TYPE parameter)
//   - encodings of the interrupt mode (IRQ_TYPE parameter)
// ---------------------------------------------------------------------------
package problema1_pio_pkg;

  // Register map (word index on the 3-bit address bus)
  localparam logic [2:0] ADDR_DATA        = 3'd0;
  localparam logic [2:0] ADDR_DIRECTION   = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK     = 3'd2;
  localparam logic [2:0] ADDR_EDGECAPTURE = 3'd3;
  localparam logic [2:0] ADDR_OUTSET      = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR    = 3'd5;

  // Edge-capture mode
  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  // Interrupt source mode
  localparam int IRQ_LEVEL = 0;
  localparam int IRQ_EDGE  = 1;

endpackage : problema1_pio_pkg

// File: rtl/problema1_pio_sync.sv
// ---------------------------------------------------------------------------
// problema1_pio_sync
// Brings the asynchronous pin vector into the clk domain through a
// SYNC_STAGES-deep flop chain, keeps one more flop of history (prev) and
// reports per-bit edges of the selected type.
//
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous active-high reset
//   in_port   in   [WIDTH] raw pin inputs (asynchronous)
//   sync_in   out  [WIDTH] synchronised pin value
//   edge_vec  out  [WIDTH] combinational edge flags (sync_in vs prev)
//
// prev follows sync_in unconditionally, so a bit that is re-purposed from
// output to input never sees a stale history and cannot fake an edge.
// ---------------------------------------------------------------------------
module problema1_pio_sync
  import problema1_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] sync_in,
  output logic [WIDTH-1:0] edge_vec
);

  // stage_q[0] is the first (metastability-exposed) stage.
  logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_q;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_d;
  logic [WIDTH-1:0]                  prev_q;
  logic [WIDTH-1:0]                  prev_d;

  assign stage_d = {stage_q[SYNC_STAGES-2:0], in_port};
  assign sync_in = stage_q[SYNC_STAGES-1];
  assign prev_d  = sync_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_q <= '0;
      prev_q  <= '0;
    end else begin
      stage_q <= stage_d;
      prev_q  <= prev_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_edge
      if (EDGE_TYPE == EDGE_FALLING) begin : g_fall
        assign edge_vec[gi] = ~sync_in[gi] & prev_q[gi];
      end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
        assign edge_vec[gi] = sync_in[gi] ^ prev_q[gi];
      end else begin : g_rise
        assign edge_vec[gi] = sync_in[gi] & ~prev_q[gi];
      end
    end
  endgenerate

endmodule : problema1_pio_sync

// File: rtl/problema1_pio_ext.sv
// ---------------------------------------------------------------------------
// problema1_pio_ext
// Avalon-MM general-purpose I/O slave with per-bit direction, synchronised
// inputs, edge capture, maskable interrupt and atomic set/clear of outputs.
//
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous active-high reset
//   address     in   [3]  word register index
//   chipselect  in   slave select
//   write_n     in   active-low write strobe (read = chipselect & write_n)
//   writedata   in   [32] write data, bits above WIDTH ignored
//   readdata    out  [32] registered read data, zero-extended
//   in_port     in   [WIDTH] external pins (asynchronous)
//   out_port    out  [WIDTH] output data register
//   oe_port     out  [WIDTH] per-bit output enable (direction register)
//   irq         out  registered interrupt request
//
// Register map: 0 DATA, 1 DIRECTION, 2 IRQMASK, 3 EDGECAPTURE (W1C),
// 4 OUTSET (write-only), 5 OUTCLEAR (write-only), 6/7 reserved (read 0).
// ---------------------------------------------------------------------------
module problema1_pio_ext
  import problema1_pio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               EDGE_TYPE   = EDGE_RISING,
  parameter int               IRQ_TYPE    = IRQ_EDGE,
  parameter int               SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe_port,
  output logic             irq
);

  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] wdata;
  logic             unused_wdata_hi;

  logic [WIDTH-1:0] out_q,  out_d;
  logic [WIDTH-1:0] dir_q,  dir_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q,  cap_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q,  irq_d;

  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] edge_vec;
  logic [WIDTH-1:0] clr_bits;
  logic [WIDTH-1:0] rd_word;
  logic [31:0]      rd_ext;

  assign wr_en = chipselect & ~write_n;
  assign rd_en = chipselect &  write_n;
  assign wdata = writedata[WIDTH-1:0];
  // Upper write-data bits are deliberately dropped.
  assign unused_wdata_hi = ^writedata;

  problema1_pio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_sync (
    .clk      (clk),
    .reset    (reset),
    .in_port  (in_port),
    .sync_in  (sync_in),
    .edge_vec (edge_vec)
  );

  // Output, direction and mask registers
  always_comb begin
    out_d  = out_q;
    dir_d  = dir_q;
    mask_d = mask_q;
    if (wr_en) begin
      case (address)
        ADDR_DATA:      out_d  = wdata;
        ADDR_DIRECTION: dir_d  = wdata;
        ADDR_IRQMASK:   mask_d = wdata;
        ADDR_OUTSET:    out_d  = out_q | wdata;
        ADDR_OUTCLEAR:  out_d  = out_q & ~wdata;
        default: ;
      endcase
    end
  end

  // Edge capture: write-1-to-clear, but a fresh edge in the same cycle
  // re-sets the bit (OR after the clear). Output-direction bits never capture.
  assign clr_bits = (wr_en && (address == ADDR_EDGECAPTURE)) ? wdata : '0;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cap
      assign cap_d[gi] = (cap_q[gi] & ~clr_bits[gi]) | (edge_vec[gi] & ~dir_q[gi]);
    end
  endgenerate

  // Read mux sees pre-write register state.
  always_comb begin
    rd_word = '0;
    case (address)
      ADDR_DATA:        rd_word = (sync_in & ~dir_q) | (out_q & dir_q);
      ADDR_DIRECTION:   rd_word = dir_q;
      ADDR_IRQMASK:     rd_word = mask_q;
      ADDR_EDGECAPTURE: rd_word = cap_q;
      default:          rd_word = '0;
    endcase
  end

  always_comb begin
    rd_ext              = '0;
    rd_ext[WIDTH-1:0]   = rd_word;
  end

  assign readdata_d = rd_en ? rd_ext : readdata_q;

  generate
    if (IRQ_TYPE == IRQ_LEVEL) begin : g_irq_level
      assign irq_d = |(sync_in & ~dir_q & mask_q);
    end else begin : g_irq_edge
      assign irq_d = |(cap_q & mask_q);
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q      <= RESET_VALUE;
      dir_q      <= '0;
      mask_q     <= '0;
      cap_q      <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      out_q      <= out_d;
      dir_q      <= dir_d;
      mask_q     <= mask_d;
      cap_q      <= cap_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign out_port = out_q;
  assign oe_port  = dir_q;
  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule : problema1_pio_ext

// File: tb/tb_problema1_pio_ext.sv
// ---------------------------------------------------------------------------
// tb_problema1_pio_ext
// Directed scenarios followed by a randomised phase, all compared against a
// behavioural model of the register map (pin history kept as a delay line).
// ---------------------------------------------------------------------------
module tb_problema1_pio_ext;

  localparam int W  = 8;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [W-1:0]  in_port;
  logic [W-1:0]  out_port;
  logic [W-1:0]  oe_port;
  logic          irq;

  always #5 clk = ~clk;

  problema1_pio_ext #(
    .WIDTH       (W),
    .RESET_VALUE (8'h00),
    .EDGE_TYPE   (0),
    .IRQ_TYPE    (1),
    .SYNC_STAGES (SS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .out_port   (out_port),
    .oe_port    (oe_port),
    .irq        (irq)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [W-1:0] m_out, m_dir, m_mask, m_cap;
  logic         m_irq;
  logic [31:0]  m_rd;
  logic [W-1:0] m_hist [0:SS];   // m_hist[0] = pin value sampled at latest edge

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_out = 8'h00; m_dir = '0; m_mask = '0; m_cap = '0; m_irq = 1'b0; m_rd = '0;
    for (int i = 0; i <= SS; i++) m_hist[i] = '0;
  endtask

  // One clock edge of the register map, evaluated from pre-edge state.
  task automatic model_step();
    logic [W-1:0] s_old, p_old, ev, clr, wd, rdw;
    logic         irq_n;
    s_old = m_hist[SS-1];
    p_old = m_hist[SS];
    ev    = s_old & ~p_old & ~m_dir;
    wd    = writedata[W-1:0];
    clr   = '0;
    irq_n = (m_cap & m_mask) != 0;
    if (chipselect && write_n) begin
      case (address)
        3'd0:    rdw = (s_old & ~m_dir) | (m_out & m_dir);
        3'd1:    rdw = m_dir;
        3'd2:    rdw = m_mask;
        3'd3:    rdw = m_cap;
        default: rdw = '0;
      endcase
      m_rd = {24'h0, rdw};
    end
    if (chipselect && !write_n) begin
      case (address)
        3'd0: m_out  = wd;
        3'd1: m_dir  = wd;
        3'd2: m_mask = wd;
        3'd3: clr    = wd;
        3'd4: m_out  = m_out | wd;
        3'd5: m_out  = m_out & ~wd;
        default: ;
      endcase
    end
    m_cap = (m_cap & ~clr) | ev;
    m_irq = irq_n;
    for (int i = SS; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = in_port;
  endtask

  task automatic check_outputs();
    chk("out_port", {24'h0, out_port}, {24'h0, m_out});
    chk("oe_port",  {24'h0, oe_port},  {24'h0, m_dir});
    chk("irq",      {31'h0, irq},      {31'h0, m_irq});
    chk("readdata", readdata,          m_rd);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_write(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    tick();
    $display("write addr=%0d data=0x%08h out=0x%02h dir=0x%02h irq=%0b", a, d, out_port, oe_port, irq);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic do_read(input logic [2:0] a);
    chipselect = 1'b1; write_n = 1'b1; address = a;
    tick();
    $display("read  addr=%0d data=0x%08h irq=%0b", a, readdata, irq);
    chipselect = 1'b0;
  endtask

  initial begin
    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = '0;
    writedata = '0; in_port = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    reset = 1'b0;

    // Set / clear of output bits
    do_write(3'd1, 32'h0000_00FF);
    do_write(3'd0, 32'h0000_000F);
    chk("data_wr", {24'h0, out_port}, 32'h0F);
    do_write(3'd4, 32'h0000_0030);
    chk("outset", {24'h0, out_port}, 32'h3F);
    do_write(3'd5, 32'h0000_0005);
    chk("outclear", {24'h0, out_port}, 32'h3A);
    do_read(3'd0);
    chk("rd_out", readdata, 32'h3A);

    // Mixed direction read
    do_write(3'd1, 32'h0000_00F0);
    do_write(3'd0, 32'hFFFF_FFA0);
    in_port = 8'h05;
    idle(SS + 1);
    do_read(3'd0);
    chk("rd_mixed", readdata, 32'hA5);
    do_read(3'd4);
    chk("rd_outset", readdata, 32'h0);

    // Quiet the pins and clear captures
    in_port = 8'h00;
    idle(SS + 1);
    do_write(3'd3, 32'h0000_00FF);
    do_read(3'd3);
    chk("cap_cleared", readdata, 32'h0);

    // Rising edge on bit0 drives irq
    do_write(3'd2, 32'h0000_0001);
    do_write(3'd1, 32'h0000_0000);
    in_port = 8'h01;
    idle(SS + 1);
    chk("irq_lag", {31'h0, irq}, 32'h0);
    do_read(3'd3);
    chk("cap_bit0", readdata, 32'h01);
    chk("irq_set", {31'h0, irq}, 32'h1);
    do_write(3'd3, 32'h0000_0001);
    chk("irq_hold", {31'h0, irq}, 32'h1);
    idle(1);
    chk("irq_drop", {31'h0, irq}, 32'h0);

    // Clear/edge collision on masked bit2
    in_port = 8'h05;
    idle(SS + 1);
    do_read(3'd3);
    chk("cap_bit2", readdata, 32'h04);
    in_port = 8'h01;
    idle(SS + 1);
    in_port = 8'h05;
    idle(SS);
    do_write(3'd3, 32'h0000_0004);
    do_read(3'd3);
    chk("collision", readdata, 32'h04);
    chk("masked_irq", {31'h0, irq}, 32'h0);

    // Output-bit exclusion and direction change
    do_write(3'd3, 32'h0000_00FF);
    do_write(3'd1, 32'h0000_0008);
    do_write(3'd2, 32'h0000_0008);
    in_port = 8'h0D;
    idle(SS + 2);
    in_port = 8'h05;
    idle(SS + 2);
    do_read(3'd3);
    chk("out_no_cap", readdata, 32'h0);
    in_port = 8'h0D;
    idle(SS + 2);
    do_write(3'd1, 32'h0000_0000);
    idle(SS + 2);
    do_read(3'd3);
    chk("dir_change", readdata, 32'h0);
    chk("dir_irq", {31'h0, irq}, 32'h0);

    // Randomised traffic against the model
    for (int n = 0; n < 300; n++) begin
      chipselect = ($urandom_range(0, 3) != 0);
      write_n    = $urandom_range(0, 1) == 1;
      address    = 3'($urandom_range(0, 7));
      writedata  = $urandom;
      if ($urandom_range(0, 3) == 0) in_port = W'($urandom);
      tick();
      if (chipselect)
        $display("rand  %s addr=%0d wdata=0x%08h rdata=0x%08h out=0x%02h irq=%0b",
                 write_n ? "rd" : "wr", address, writedata, readdata, out_port, irq);
    end
    chipselect = 1'b0; write_n = 1'b1;

    // Asynchronous reset mid-run with irq high
    do_write(3'd1, 32'h0000_0000);
    do_write(3'd2, 32'h0000_00FF);
    in_port = 8'h00;
    idle(SS + 2);
    in_port = 8'hFF;
    idle(SS + 3);
    do_write(3'd0, 32'h0000_00A5);
    do_write(3'd1, 32'h0000_00FF);
    chk("pre_rst_out", {24'h0, out_port}, 32'hA5);
    chk("pre_rst_irq", {31'h0, irq}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("rst_out", {24'h0, out_port}, 32'h00);
    chk("rst_oe",  {24'h0, oe_port},  32'h00);
    chk("rst_irq", {31'h0, irq},      32'h0);
    chk("rst_rd",  readdata,          32'h0);
    @(negedge clk);
    reset = 1'b0;
    idle(SS + 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_problema1_pio_ext
